ahb_to_apb_bridge: RTL and testbench



---
 rtl/ahb_apb_pkg.sv | 25 ++
 rtl/ahb_apb_strb_gen.sv | 22 ++
 rtl/ahb_to_apb_bridge.sv | 141 ++++++++++++++
 tb/tb_ahb_to_apb_bridge.sv | 387 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_apb_pkg.sv
// Shared types and AHB/APB encodings for the AHB-Lite to APB4 bridge.
package ahb_apb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_WAIT,
        SETUP,
        ACCESS,
        ERR1,
        ERR2
    } state_t;

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_BUSY   = 2'b01;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;
    localparam logic [1:0] TRANS_SEQ    = 2'b11;

    localparam logic RESP_OKAY  = 1'b0;
    localparam logic RESP_ERROR = 1'b1;

    localparam logic [2:0] SIZE_BYTE = 3'b000;
    localparam logic [2:0] SIZE_HALF = 3'b001;
    localparam logic [2:0] SIZE_WORD = 3'b010;

endpackage

// File: rtl/ahb_apb_strb_gen.sv
// APB write strobe generation from transfer size and low address bits.
module ahb_apb_strb_gen
    import ahb_apb_pkg::*;
(
    input  logic [2:0] size,
    input  logic [1:0] addr,
    input  logic       write,
    output logic [3:0] strb
);

    always_comb begin
        strb = 4'b0000;
        if (write) begin
            unique case (1'b1)
                (size == SIZE_BYTE): strb = 4'b0001 << addr;
                (size == SIZE_HALF): strb = addr[1] ? 4'b1100 : 4'b0011;
                default:             strb = 4'b1111;
            endcase
        end
    end

endmodule

// File: rtl/ahb_to_apb_bridge.sv
// AHB-Lite slave to APB4 master bridge; one APB setup+access per AHB transfer.
module ahb_to_apb_bridge
    import ahb_apb_pkg::*;
#(
    parameter int ADDRWIDTH = 16
) (
    input  logic                 HCLK,
    input  logic                 HRESET,
    input  logic                 HSEL,
    input  logic [31:0]          HADDR,
    input  logic [1:0]           HTRANS,
    input  logic                 HWRITE,
    input  logic [2:0]           HSIZE,
    input  logic [3:0]           HPROT,
    input  logic [31:0]          HWDATA,
    input  logic                 HREADY,
    output logic                 HREADYOUT,
    output logic                 HRESP,
    output logic [31:0]          HRDATA,
    output logic                 PSEL,
    output logic                 PENABLE,
    output logic [ADDRWIDTH-1:0] PADDR,
    output logic                 PWRITE,
    output logic [31:0]          PWDATA,
    output logic [3:0]           PSTRB,
    output logic [2:0]           PPROT,
    input  logic [31:0]          PRDATA,
    input  logic                 PREADY,
    input  logic                 PSLVERR
);

    state_t      state;
    state_t      state_next;
    logic        accept;
    logic        can_accept;
    logic        take;
    logic [2:0]  size_q;
    logic [1:0]  lsb_q;
    logic [3:0]  strb;
    logic        unused_bits;

    assign accept     = HSEL & HTRANS[1] & HREADY;
    assign can_accept = (state == IDLE) || (state == ERR2);
    assign take       = accept & can_accept;

    assign unused_bits = ^{HADDR[31:ADDRWIDTH], HTRANS[0], HPROT[3:2]};

    ahb_apb_strb_gen u_strb (
        .size  (size_q),
        .addr  (lsb_q),
        .write (PWRITE),
        .strb  (strb)
    );

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        HREADYOUT  = 1'b0;
        HRESP      = RESP_OKAY;
        PSEL       = 1'b0;
        PENABLE    = 1'b0;
        unique case (state)
            IDLE: begin
                HREADYOUT = 1'b1;
                if (accept) begin
                    state_next = HWRITE ? WR_WAIT : SETUP;
                end
            end
            WR_WAIT: begin
                state_next = SETUP;
            end
            SETUP: begin
                PSEL       = 1'b1;
                state_next = ACCESS;
            end
            ACCESS: begin
                PSEL    = 1'b1;
                PENABLE = 1'b1;
                if (PREADY) begin
                    state_next = PSLVERR ? ERR1 : IDLE;
                end
            end
            ERR1: begin
                HRESP      = RESP_ERROR;
                state_next = ERR2;
            end
            ERR2: begin
                HREADYOUT  = 1'b1;
                HRESP      = RESP_ERROR;
                state_next = IDLE;
                if (accept) begin
                    state_next = HWRITE ? WR_WAIT : SETUP;
                end
            end
            default: begin
                HREADYOUT  = 1'b1;
                state_next = IDLE;
            end
        endcase
    end

    // Address-phase attributes are latched on accept and held through ACCESS.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            PADDR  <= '0;
            PWRITE <= 1'b0;
            PPROT  <= 3'b000;
            PWDATA <= 32'h0;
            PSTRB  <= 4'b0000;
            HRDATA <= 32'h0;
            size_q <= 3'b000;
            lsb_q  <= 2'b00;
        end else begin
            if (take) begin
                PADDR  <= {HADDR[ADDRWIDTH-1:2], 2'b00};
                PWRITE <= HWRITE;
                PPROT  <= {~HPROT[0], 1'b0, HPROT[1]};
                size_q <= HSIZE;
                lsb_q  <= HADDR[1:0];
                if (!HWRITE) begin
                    PSTRB <= 4'b0000;
                end
            end
            if (state == WR_WAIT) begin
                PWDATA <= HWDATA;
                PSTRB  <= strb;
            end
            if (state == ACCESS && PREADY && !PSLVERR && !PWRITE) begin
                HRDATA <= PRDATA;
            end
        end
    end

endmodule

// File: tb/tb_ahb_to_apb_bridge.sv
// Randomized scoreboard bench for ahb_to_apb_bridge with an APB slave model.
module tb_ahb_to_apb_bridge;

    localparam int K_XFER  = 0;
    localparam int K_BUSY  = 1;
    localparam int K_UNSEL = 2;
    localparam int K_IDLE  = 3;

    logic        HCLK = 1'b0;
    logic        HRESET = 1'b1;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [3:0]  HPROT;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic        HRESP;
    logic [31:0] HRDATA;
    logic        PSEL;
    logic        PENABLE;
    logic [15:0] PADDR;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic [3:0]  PSTRB;
    logic [2:0]  PPROT;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    assign HREADY = HREADYOUT;

    always #5 HCLK = ~HCLK;

    ahb_to_apb_bridge #(.ADDRWIDTH(16)) dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .HSEL      (HSEL),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HPROT     (HPROT),
        .HWDATA    (HWDATA),
        .HREADY    (HREADY),
        .HREADYOUT (HREADYOUT),
        .HRESP     (HRESP),
        .HRDATA    (HRDATA),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PADDR     (PADDR),
        .PWRITE    (PWRITE),
        .PWDATA    (PWDATA),
        .PSTRB     (PSTRB),
        .PPROT     (PPROT),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR)
    );

    typedef struct {
        int        kind;
        bit        wr;
        bit        seq;
        bit [31:0] addr;
        bit [2:0]  size;
        bit [3:0]  prot;
        bit [31:0] wdata;
        int        waits;
        bit        err;
        bit [31:0] prdata;
    } stim_t;

    typedef struct {
        bit [15:0] paddr;
        bit        pwrite;
        bit [2:0]  pprot;
        bit [3:0]  pstrb;
        bit [31:0] pwdata;
        int        waits;
        bit        err;
        bit [31:0] prdata;
    } apb_t;

    typedef struct {
        int        cycles;
        bit        err;
        bit        wr;
        bit [31:0] prdata;
    } ahb_t;

    stim_t stim_q[$];
    apb_t  apb_q[$];
    ahb_t  ahb_q[$];

    int        checks = 0;
    int        errors = 0;
    bit [31:0] m_pwdata = 0;
    bit [31:0] m_rdata = 0;
    bit        in_data = 0;
    bit        rdy_s = 0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit [3:0] exp_strb(bit wr, bit [2:0] size, bit [1:0] a);
        bit [3:0] one;
        one = 4'b0001;
        if (!wr) return 4'b0000;
        if (size == 3'd0) return one << a;
        if (size == 3'd1) return a[1] ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    task automatic issue(stim_t s);
        apb_t a;
        ahb_t h;
        if (s.kind == K_XFER) begin
            if (s.wr) m_pwdata = s.wdata;
            a.paddr  = s.addr[15:0] & 16'hFFFC;
            a.pwrite = s.wr;
            a.pprot  = {~s.prot[0], 1'b0, s.prot[1]};
            a.pstrb  = exp_strb(s.wr, s.size, s.addr[1:0]);
            a.pwdata = m_pwdata;
            a.waits  = s.waits;
            a.err    = s.err;
            a.prdata = s.prdata;
            h.cycles = (s.wr ? 4 : 3) + s.waits + (s.err ? 1 : 0);
            h.err    = s.err;
            h.wr     = s.wr;
            h.prdata = s.prdata;
            apb_q.push_back(a);
            ahb_q.push_back(h);
        end
        stim_q.push_back(s);
    endtask

    task automatic xfer(bit wr, bit [31:0] addr, bit [2:0] size,
                        bit [31:0] wdata, int waits, bit err,
                        bit [31:0] prdata);
        stim_t s;
        s.kind   = K_XFER;
        s.wr     = wr;
        s.seq    = 1'($urandom);
        s.addr   = addr;
        s.size   = size;
        s.prot   = 4'($urandom);
        s.wdata  = wdata;
        s.waits  = waits;
        s.err    = err;
        s.prdata = prdata;
        issue(s);
    endtask

    task automatic nox(int kind);
        stim_t s;
        s.kind   = kind;
        s.wr     = 1'($urandom);
        s.seq    = 1'b0;
        s.addr   = $urandom;
        s.size   = 3'($urandom_range(0, 2));
        s.prot   = 4'($urandom);
        s.wdata  = $urandom;
        s.waits  = 0;
        s.err    = 1'b0;
        s.prdata = 0;
        issue(s);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((stim_q.size() != 0 || ahb_q.size() != 0 || in_data)
               && n < 3000) begin
            @(negedge HCLK);
            n++;
        end
        chk("drain_timeout", 64'(n < 3000), 64'd1);
        repeat (3) @(negedge HCLK);
    endtask

    task automatic chk_reset();
        chk("rst_hreadyout", HREADYOUT, 1);
        chk("rst_hresp", HRESP, 0);
        chk("rst_hrdata", HRDATA, 0);
        chk("rst_psel", PSEL, 0);
        chk("rst_penable", PENABLE, 0);
        chk("rst_paddr", PADDR, 0);
        chk("rst_pwrite", PWRITE, 0);
        chk("rst_pwdata", PWDATA, 0);
        chk("rst_pstrb", PSTRB, 0);
        chk("rst_pprot", PPROT, 0);
    endtask

    always @(negedge HCLK) rdy_s <= HREADY;

    // AHB master: address phase advances only when HREADY was high at the edge.
    initial begin : driver
        stim_t cur;
        bit av;
        av = 0;
        HSEL = 0; HTRANS = 2'b00; HADDR = 0; HWRITE = 0;
        HSIZE = 0; HPROT = 0; HWDATA = 0;
        forever begin
            @(posedge HCLK);
            #1;
            if (HRESET) begin
                av = 0;
                HSEL = 0;
                HTRANS = 2'b00;
            end else if (rdy_s) begin
                if (av && cur.kind == K_XFER && cur.wr) HWDATA = cur.wdata;
                else HWDATA = $urandom;
                av = 0;
                HSEL = 0;
                HTRANS = 2'b00;
                if (stim_q.size() != 0) begin
                    cur = stim_q.pop_front();
                    av = 1;
                    HADDR = cur.addr;
                    HWRITE = cur.wr;
                    HSIZE = cur.size;
                    HPROT = cur.prot;
                    case (cur.kind)
                        K_XFER:  begin HSEL = 1; HTRANS = cur.seq ? 2'b11 : 2'b10; end
                        K_BUSY:  begin HSEL = 1; HTRANS = 2'b01; end
                        K_UNSEL: begin HSEL = 0; HTRANS = 2'b10; end
                        default: begin HSEL = 1; HTRANS = 2'b00; end
                    endcase
                end
            end
        end
    end

    // AHB monitor: counts data-phase cycles and checks the response.
    initial begin : ahb_mon
        int cnt;
        ahb_t e;
        cnt = 0;
        forever begin
            @(negedge HCLK);
            if (HRESET) begin
                in_data = 0;
                continue;
            end
            if (in_data) begin
                cnt++;
                if (HREADYOUT) begin
                    if (ahb_q.size() == 0) begin
                        chk("ahb_unexpected_done", 1, 0);
                    end else begin
                        e = ahb_q.pop_front();
                        if (!e.wr && !e.err) m_rdata = e.prdata;
                        chk("data_cycles", cnt, e.cycles);
                        chk("done_hresp", HRESP, e.err);
                        chk("done_hrdata", HRDATA, m_rdata);
                    end
                    in_data = 0;
                end else if (cnt > 300) begin
                    chk("ahb_timeout", 0, 1);
                    in_data = 0;
                end else if (ahb_q.size() != 0) begin
                    chk("wait_hresp", HRESP,
                        64'(ahb_q[0].err && cnt == ahb_q[0].cycles - 1));
                end
            end else begin
                chk("idle_resp", {HREADYOUT, HRESP}, 2'b10);
            end
            if (HSEL && HTRANS[1] && HREADY) begin
                in_data = 1;
                cnt = 0;
            end
        end
    end

    // APB slave model: checks the setup phase, then drives the response.
    initial begin : apb_mon
        apb_t e;
        bit ev;
        int w;
        ev = 0;
        w = 0;
        PREADY = 0; PSLVERR = 0; PRDATA = 0;
        forever begin
            @(negedge HCLK);
            PREADY = 1'($urandom);
            PSLVERR = 1'($urandom);
            PRDATA = $urandom;
            if (HRESET) begin
                ev = 0;
            end else if (PSEL && !PENABLE) begin
                if (apb_q.size() == 0) begin
                    chk("apb_unexpected_psel", PSEL, 0);
                    ev = 0;
                end else begin
                    e = apb_q.pop_front();
                    ev = 1;
                    w = e.waits;
                    chk("setup_paddr", PADDR, e.paddr);
                    chk("setup_pwrite", PWRITE, e.pwrite);
                    chk("setup_pprot", PPROT, e.pprot);
                    chk("setup_pstrb", PSTRB, e.pstrb);
                    chk("setup_pwdata", PWDATA, e.pwdata);
                end
            end else if (PSEL && PENABLE && ev) begin
                chk("access_stable", {PADDR, PWRITE, PPROT, PSTRB, PWDATA},
                    {e.paddr, e.pwrite, e.pprot, e.pstrb, e.pwdata});
                PREADY = (w == 0);
                if (w == 0) begin
                    PSLVERR = e.err;
                    PRDATA = e.prdata;
                    ev = 0;
                end else begin
                    w--;
                end
            end
        end
    end

    initial begin : main
        int n;
        HRESET = 1;
        repeat (3) @(posedge HCLK);
        #1;
        chk_reset();
        @(negedge HCLK);
        #2 HRESET = 0;

        xfer(0, 32'h0000_0124, 3'd2, 32'h0, 0, 0, 32'hCAFE_F00D);
        xfer(1, 32'h0000_0042, 3'd0, 32'h00AB_0000, 3, 0, 32'h0);
        xfer(0, 32'h0000_0080, 3'd2, 32'h0, 0, 1, $urandom);
        nox(K_IDLE);
        xfer(1, 32'h0000_0010, 3'd2, $urandom, 0, 0, 32'h0);
        xfer(0, 32'h0000_0014, 3'd2, 32'h0, 0, 0, $urandom);
        nox(K_BUSY);
        nox(K_UNSEL);
        xfer(1, 32'h0000_0106, 3'd1, $urandom, 1, 0, 32'h0);
        xfer(1, 32'h0000_0101, 3'd1, $urandom, 0, 1, 32'h0);
        nox(K_IDLE);
        drain();

        for (int i = 0; i < 120; i++) begin
            int k;
            k = $urandom_range(0, 9);
            if (k < 7) begin
                xfer(1'($urandom), $urandom, 3'($urandom_range(0, 3)),
                     $urandom, $urandom_range(0, 3),
                     ($urandom_range(0, 5) == 0), $urandom);
            end else begin
                nox(k - 6);
            end
        end
        drain();

        xfer(0, 32'h0000_0200, 3'd2, 32'h0, 50, 0, 32'h1234_5678);
        n = 0;
        do begin
            @(negedge HCLK);
            n++;
        end while (!(PSEL && PENABLE) && n < 100);
        chk("reach_access", 64'(PSEL && PENABLE), 1);
        #2 HRESET = 1;
        @(posedge HCLK);
        #1;
        chk_reset();
        ahb_q.delete();
        apb_q.delete();
        stim_q.delete();
        m_pwdata = 0;
        m_rdata = 0;
        @(negedge HCLK);
        #2 HRESET = 0;
        xfer(0, 32'h0000_0204, 3'd2, 32'h0, 1, 0, 32'h5A5A_A5A5);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
